// File: rtl/piso_frame_receiver_if.sv
// ---------------------------------------------------------------------------
// piso_frame_receiver_if
//
// Purpose : bundles the serial input side, the abort control and the
//           parallel valid/ready output side of the PISO frame receiver.
//
// Signals :
//   serial_in     - serial data bit, frame MSB first
//   serial_valid  - qualifies serial_in on a clock edge
//   clear         - synchronous abort of the partial frame, clears overrun
//   out_ready     - consumer accepts parallel_out when out_valid is high
//   parallel_out  - last completed word (registered)
//   out_valid     - parallel_out holds an unconsumed word
//   overrun       - sticky flag: at least one completed word was dropped
//   frame_busy    - a partial frame is being held
//
// Modports:
//   slave  - the receiver itself
//   master - the environment (serial driver plus parallel consumer)
// ---------------------------------------------------------------------------
interface piso_frame_receiver_if #(
    parameter int WIDTH = 4
);
    logic             serial_in;
    logic             serial_valid;
    logic             clear;
    logic             out_ready;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             overrun;
    logic             frame_busy;

    modport slave (
        input  serial_in,
        input  serial_valid,
        input  clear,
        input  out_ready,
        output parallel_out,
        output out_valid,
        output overrun,
        output frame_busy
    );

    modport master (
        output serial_in,
        output serial_valid,
        output clear,
        output out_ready,
        input  parallel_out,
        input  out_valid,
        input  overrun,
        input  frame_busy
    );
endinterface : piso_frame_receiver_if

// File: rtl/piso_frame_receiver.sv
// ---------------------------------------------------------------------------
// piso_frame_receiver
//
// Purpose : receiving end of a PISO serial link. Qualified serial bits are
//           shifted in MSB first; every WIDTH-th sampled bit completes a
//           word, which is placed in a one-entry valid/ready holding
//           register. A completed word that finds the holding register
//           occupied (and not being drained on the same edge) is dropped
//           and the sticky overrun flag is raised.
//
// Ports   :
//   clk      - rising-edge clock, the only clock
//   reset_n  - synchronous active-low reset
//   bus      - piso_frame_receiver_if.slave (serial input, clear,
//              out_ready in; parallel_out, out_valid, overrun,
//              frame_busy out; all outputs registered)
//
// Parameters:
//   WIDTH    - frame length in bits, 2..32
// ---------------------------------------------------------------------------
module piso_frame_receiver #(
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    piso_frame_receiver_if.slave         bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Only the WIDTH-1 most recent bits need storing: the last bit of a
    // frame goes straight from serial_in into the completed word.
    logic [WIDTH-2:0] r_sh;
    logic [CW-1:0]    r_cnt;
    state_t           r_state;
    logic [WIDTH-1:0] r_parallel_out;
    logic             r_out_valid;
    logic             r_overrun;

    logic [WIDTH-2:0] w_sh_next;
    logic [CW-1:0]    w_cnt_next;
    state_t           w_state_next;
    logic [WIDTH-1:0] w_parallel_out_next;
    logic             w_out_valid_next;
    logic             w_overrun_next;

    logic [WIDTH-1:0] w_word;
    logic             w_xfer;
    logic             w_complete;
    logic             w_load;
    logic             w_drop;

    // Candidate word: stored bits followed by the bit currently on the line.
    assign w_word = {r_sh, bus.serial_in};

    // Handshake: consumer takes the held word this edge.
    assign w_xfer = r_out_valid & bus.out_ready;

    // Completion/load/drop decode; clear suppresses sampling entirely.
    always_comb begin
        w_complete = 1'b0;
        w_load     = 1'b0;
        w_drop     = 1'b0;
        if (!bus.clear && bus.serial_valid && (r_cnt == LAST_BIT)) begin
            w_complete = 1'b1;
            // A slot frees up either because it is empty or because the
            // consumer drains it on this very edge.
            if (!r_out_valid || w_xfer) begin
                w_load = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
        end else begin
            w_complete = 1'b0;
        end
    end

    // Shift register and bit counter next-state.
    always_comb begin
        w_sh_next  = r_sh;
        w_cnt_next = r_cnt;
        if (bus.clear) begin
            w_sh_next  = '0;
            w_cnt_next = CNT_ZERO;
        end else if (bus.serial_valid) begin
            if (w_complete) begin
                w_sh_next  = '0;
                w_cnt_next = CNT_ZERO;
            end else begin
                w_sh_next  = w_word[WIDTH-2:0];
                w_cnt_next = r_cnt + CNT_ONE;
            end
        end else begin
            w_sh_next  = r_sh;
            w_cnt_next = r_cnt;
        end
    end

    // FSM next-state: RECV exactly when a partial frame will be held.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_cnt_next != CNT_ZERO) begin
                    w_state_next = RECV;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RECV: begin
                if (w_cnt_next == CNT_ZERO) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = RECV;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Holding register, valid flag and sticky overrun next-state.
    always_comb begin
        w_parallel_out_next = r_parallel_out;
        w_out_valid_next    = r_out_valid;
        w_overrun_next      = r_overrun;
        if (w_load) begin
            w_parallel_out_next = w_word;
            w_out_valid_next    = 1'b1;
        end else if (w_xfer) begin
            // parallel_out keeps its last value after being consumed.
            w_out_valid_next    = 1'b0;
        end else begin
            w_out_valid_next    = r_out_valid;
        end
        if (bus.clear) begin
            w_overrun_next = 1'b0;
        end else if (w_drop) begin
            w_overrun_next = 1'b1;
        end else begin
            w_overrun_next = r_overrun;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sh           <= '0;
            r_cnt          <= CNT_ZERO;
            r_state        <= IDLE;
            r_parallel_out <= '0;
            r_out_valid    <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_sh           <= w_sh_next;
            r_cnt          <= w_cnt_next;
            r_state        <= w_state_next;
            r_parallel_out <= w_parallel_out_next;
            r_out_valid    <= w_out_valid_next;
            r_overrun      <= w_overrun_next;
        end
    end

    assign bus.parallel_out = r_parallel_out;
    assign bus.out_valid    = r_out_valid;
    assign bus.overrun      = r_overrun;
    assign bus.frame_busy   = (r_state == RECV);

endmodule : piso_frame_receiver

// File: tb/tb_piso_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_piso_frame_receiver
//
// Directed scenarios followed by a randomized run. A behavioural model keeps
// the frame being assembled as an integer plus a bit count and applies the
// receiver's rules once per clock edge; every output is compared after every
// edge, and key scenario results are also compared against fixed constants.
// ---------------------------------------------------------------------------
module tb_piso_frame_receiver;

    localparam int W = 4;

    logic clk;
    logic reset_n;

    piso_frame_receiver_if #(.WIDTH(W)) bus ();

    piso_frame_receiver #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int          m_cnt   = 0;
    int unsigned m_acc   = 0;
    int unsigned m_po    = 0;
    bit          m_valid = 1'b0;
    bit          m_ovr   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one edge of the receiver's rules to the model.
    task automatic model_edge(input bit rst, input bit si, input bit sv,
                              input bit clr, input bit rdy);
        bit xfer;
        bit loaded;
        if (!rst) begin
            m_cnt = 0; m_acc = 0; m_po = 0; m_valid = 0; m_ovr = 0;
        end else begin
            xfer   = m_valid && rdy;
            loaded = 0;
            if (clr) begin
                m_cnt = 0; m_acc = 0; m_ovr = 0;
            end else if (sv) begin
                m_acc = m_acc * 2 + si;
                m_cnt = m_cnt + 1;
                if (m_cnt == W) begin
                    if (!m_valid || xfer) begin
                        m_po   = m_acc;
                        loaded = 1;
                    end else begin
                        m_ovr = 1;
                    end
                    m_acc = 0;
                    m_cnt = 0;
                end
            end
            if (loaded)    m_valid = 1;
            else if (xfer) m_valid = 0;
        end
    endtask

    // Drive one cycle, advance the model, then compare all outputs.
    task automatic step(input bit rst, input bit si, input bit sv,
                        input bit clr, input bit rdy);
        reset_n          = rst;
        bus.serial_in    = si;
        bus.serial_valid = sv;
        bus.clear        = clr;
        bus.out_ready    = rdy;
        @(posedge clk);
        model_edge(rst, si, sv, clr, rdy);
        #1;
        chk("model_parallel_out", 32'(bus.parallel_out), m_po);
        chk("model_out_valid",    32'(bus.out_valid),    32'(m_valid));
        chk("model_overrun",      32'(bus.overrun),      32'(m_ovr));
        chk("model_frame_busy",   32'(bus.frame_busy),   32'(m_cnt != 0));
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit rdy);
        for (int i = W - 1; i >= 0; i--) step(1, w[i], 1, 0, rdy);
    endtask

    logic [W-1:0] pat;

    initial begin
        reset_n = 1'b0; bus.serial_in = 1'b0; bus.serial_valid = 1'b0;
        bus.clear = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);

        // Reset with active serial traffic
        step(0, 1, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        chk("rst_po",    32'(bus.parallel_out), 32'h0);
        chk("rst_valid", 32'(bus.out_valid),    32'h0);
        chk("rst_ovr",   32'(bus.overrun),      32'h0);
        chk("rst_busy",  32'(bus.frame_busy),   32'h0);

        // Basic frame 1011
        step(1, 1, 1, 0, 1); chk("basic_busy1", 32'(bus.frame_busy), 32'h1);
        step(1, 0, 1, 0, 1); chk("basic_busy2", 32'(bus.frame_busy), 32'h1);
        step(1, 1, 1, 0, 1); chk("basic_busy3", 32'(bus.frame_busy), 32'h1);
        step(1, 1, 1, 0, 1);
        chk("basic_valid", 32'(bus.out_valid),    32'h1);
        chk("basic_po",    32'(bus.parallel_out), 32'hB);
        chk("basic_busy4", 32'(bus.frame_busy),   32'h0);
        step(1, 0, 0, 0, 1);
        chk("basic_pulse", 32'(bus.out_valid), 32'h0);

        // Gapped frame 0110
        pat = 4'b0110;
        for (int i = W - 1; i >= 0; i--) begin
            step(1, pat[i], 1, 0, 1);
            if (i != 0) begin
                for (int g = 0; g < 3; g++) step(1, 1, 0, 0, 1);
                chk("gap_busy", 32'(bus.frame_busy), 32'h1);
            end
        end
        chk("gap_valid", 32'(bus.out_valid),    32'h1);
        chk("gap_po",    32'(bus.parallel_out), 32'h6);
        step(1, 0, 0, 0, 1);
        chk("gap_pulse", 32'(bus.out_valid), 32'h0);

        // Back-pressure: second word dropped
        send_word(4'b1011, 0);
        send_word(4'b0110, 0);
        chk("bp_valid", 32'(bus.out_valid),    32'h1);
        chk("bp_po",    32'(bus.parallel_out), 32'hB);
        chk("bp_ovr",   32'(bus.overrun),      32'h1);
        step(1, 0, 0, 0, 1);
        chk("bp_drain_valid", 32'(bus.out_valid), 32'h0);
        chk("bp_drain_ovr",   32'(bus.overrun),   32'h1);

        // Clear overrun, then completion simultaneous with transfer
        step(1, 0, 0, 1, 0);
        chk("clr_ovr", 32'(bus.overrun), 32'h0);
        send_word(4'b1011, 0);
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 1);
        chk("sim_po",    32'(bus.parallel_out), 32'h6);
        chk("sim_valid", 32'(bus.out_valid),    32'h1);
        chk("sim_ovr",   32'(bus.overrun),      32'h0);
        step(1, 0, 0, 0, 1);

        // Abort via clear
        step(1, 1, 1, 0, 1);
        step(1, 1, 1, 0, 1);
        step(1, 1, 1, 1, 1);
        chk("clr_busy", 32'(bus.frame_busy), 32'h0);
        send_word(4'b1100, 1);
        chk("clr_po",    32'(bus.parallel_out), 32'hC);
        chk("clr_ovr2",  32'(bus.overrun),      32'h0);
        step(1, 0, 0, 0, 1);

        // Abort via reset mid-frame
        step(1, 1, 1, 0, 1);
        step(1, 1, 1, 0, 1);
        step(0, 1, 1, 0, 1);
        send_word(4'b1100, 1);
        chk("rstab_po",  32'(bus.parallel_out), 32'hC);
        chk("rstab_ovr", 32'(bus.overrun),      32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_piso_frame_receiver
